// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, bit order and SCLK divider.
// A single registered FSM drives every pin, so there are no combinational paths to the outputs.
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              start_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic              miso_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              spi_done_tick_o,
  output logic              ready_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_n_o
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_PER = CNT_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic [DATA_W-1:0]   dout_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    clkdiv_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cpol_q;
  logic                cpha_q;
  logic                lsb_q;
  logic                sclk_q;
  logic                mosi_q;
  logic [NUM_CS-1:0]   cs_n_q;
  logic                ready_q;
  logic                done_q;

  logic [CNT_W-1:0]    per_d;
  logic                div_hit;

  // Bit position in the word for half-period index per (two half-periods per bit).
  function automatic logic [IDX_W-1:0] bit_pos(input logic [CNT_W-1:0] per, input logic lsb);
    logic [IDX_W-1:0] b;
    b = per[CNT_W-1:1];
    return lsb ? b : (IDX_W'(DATA_W - 1) - b);
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) cs[i] = 1'b0;
    end
    return cs;
  endfunction

  always_comb begin
    per_d   = cnt_q + CNT_W'(1);
    div_hit = (div_q == clkdiv_q);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      div_q    <= '0;
      clkdiv_q <= '0;
      cnt_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= '1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sclk_q <= cpol_i;
          if (start_i && ready_q) begin
            tx_q     <= din_i;
            rx_q     <= '0;
            cpol_q   <= cpol_i;
            cpha_q   <= cpha_i;
            lsb_q    <= lsb_first_i;
            clkdiv_q <= clk_div_i;
            div_q    <= '0;
            cnt_q    <= '0;
            cs_n_q   <= cs_decode(cs_sel_i);
            mosi_q   <= cpha_i ? 1'b0 : (lsb_first_i ? din_i[0] : din_i[DATA_W-1]);
            ready_q  <= 1'b0;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_hit) begin
            // First leading edge: half-period 0 begins.
            div_q   <= '0;
            cnt_q   <= '0;
            sclk_q  <= ~cpol_q;
            state_q <= S_XFER;
            if (cpha_q) mosi_q <= tx_q[bit_pos('0, lsb_q)];
            else        rx_q[bit_pos('0, lsb_q)] <= miso_i;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_XFER: begin
          if (div_hit) begin
            div_q <= '0;
            if (cnt_q == LAST_PER) begin
              state_q <= S_HOLD;
            end else begin
              cnt_q  <= per_d;
              sclk_q <= cpol_q ^ ~per_d[0];
              if (!per_d[0]) begin
                if (cpha_q) mosi_q <= tx_q[bit_pos(per_d, lsb_q)];
                else        rx_q[bit_pos(per_d, lsb_q)] <= miso_i;
              end else begin
                if (cpha_q)                  rx_q[bit_pos(per_d, lsb_q)] <= miso_i;
                else if (per_d != LAST_PER) mosi_q <= tx_q[bit_pos(per_d + CNT_W'(1), lsb_q)];
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (div_hit) begin
            div_q   <= '0;
            done_q  <= 1'b1;
            dout_q  <= rx_q;
            cs_n_q  <= '1;
            mosi_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          sclk_q  <= cpol_i;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout_o          = dout_q;
  assign spi_done_tick_o = done_q;
  assign ready_o         = ready_q;
  assign sclk_o          = sclk_q;
  assign mosi_o          = mosi_q;
  assign cs_n_o          = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: directed mode/boundary transfers plus randomized ones,
// with pin-level expectations derived from cycle offsets after the accepting edge.
module tb_spi_master_cfg;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  din_i;
  logic        start_i;
  logic [2:0]  cs_sel_i;
  logic        cpol_i;
  logic        cpha_i;
  logic        lsb_first_i;
  logic [15:0] clk_div_i;
  logic        miso_i;
  logic [7:0]  dout_o;
  logic        spi_done_tick_o;
  logic        ready_o;
  logic        sclk_o;
  logic        mosi_o;
  logic [3:0]  cs_n_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] prev_dout;

  spi_master_cfg #(.DATA_W(8), .NUM_CS(4), .DIV_W(16), .CS_W(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .din_i(din_i), .start_i(start_i),
    .cs_sel_i(cs_sel_i), .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_first_i(lsb_first_i),
    .clk_div_i(clk_div_i), .miso_i(miso_i), .dout_o(dout_o),
    .spi_done_tick_o(spi_done_tick_o), .ready_o(ready_o), .sclk_o(sclk_o),
    .mosi_o(mosi_o), .cs_n_o(cs_n_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // i-th transmitted bit of word w in the chosen order.
  function automatic logic bit_of(input logic [7:0] w, input int i, input bit lsb);
    logic [7:0] v;
    v = w;
    return lsb ? v[i] : v[7 - i];
  endfunction

  // Index of the bit on the data line at cycle offset c; -1 means undefined.
  function automatic int line_idx(input int c, input int h, input bit cpha);
    int k;
    if (c < h) return cpha ? -1 : 0;
    if (c < 17 * h) begin
      k = (c - h) / h;
      if (cpha) return k / 2;
      return ((k + 1) / 2 > 7) ? 7 : (k + 1) / 2;
    end
    return 7;
  endfunction

  function automatic logic exp_sclk(input int c, input int h, input bit cpol);
    int k;
    if (c >= h && c < 17 * h) begin
      k = (c - h) / h;
      return cpol ^ (k % 2 == 0);
    end
    return cpol;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " dout"}, dout_o, 0);
    check({tag, " done"}, spi_done_tick_o, 0);
    check({tag, " ready"}, ready_o, 1);
    check({tag, " sclk"}, sclk_o, 0);
    check({tag, " mosi"}, mosi_o, 0);
    check({tag, " cs"}, cs_n_o, 4'hF);
  endtask

  // Starts one transfer from a negedge and checks every pin each cycle through DONE.
  task automatic run_xfer(input logic [7:0] din, input logic [7:0] sw, input bit loopback,
                          input bit cpol, input bit cpha, input bit lsb, input int div,
                          input int sel, input bit keep_start, input int pulse_c,
                          input int abort_c, input int exp_gap);
    int h, l, n, idx;
    logic [3:0] exp_cs;
    h = div + 1;
    l = h * 18;
    n = 0;
    exp_cs = 4'hF;
    if (sel < 4) exp_cs[sel] = 1'b0;
    din_i = din; cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb;
    clk_div_i = 16'(div); cs_sel_i = 3'(sel); start_i = 1'b1;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
      check("gap cs", cs_n_o, 4'hF);
    end
    check("ready at start", ready_o, 1);
    if (exp_gap >= 0) check("b2b gap", n, exp_gap);
    @(posedge clk_i);
    for (int c = 0; c <= l; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        if (!keep_start) start_i = 1'b0;
        din_i = 8'($urandom); cpol_i = 1'($urandom); cpha_i = 1'($urandom);
        lsb_first_i = 1'($urandom); clk_div_i = 16'($urandom_range(0, 7));
        cs_sel_i = 3'($urandom);
      end
      if (c == pulse_c) start_i = 1'b1;
      if (c == pulse_c + 1) start_i = 1'b0;
      if (c == abort_c) begin
        reset_i = 1'b0;
        #1;
        check_reset("abort");
        return;
      end
      idx = line_idx(c, h, cpha);
      if (c < l) begin
        check($sformatf("cs c=%0d", c), cs_n_o, exp_cs);
        check($sformatf("ready c=%0d", c), ready_o, 0);
        check($sformatf("done c=%0d", c), spi_done_tick_o, 0);
        check($sformatf("sclk c=%0d", c), sclk_o, exp_sclk(c, h, cpol));
        check($sformatf("dout hold c=%0d", c), dout_o, prev_dout);
        if (idx >= 0) check($sformatf("mosi c=%0d", c), mosi_o, bit_of(din, idx, lsb));
      end else begin
        check("done tick", spi_done_tick_o, 1);
        check("dout", dout_o, sw);
        check("done cs", cs_n_o, 4'hF);
        check("done mosi", mosi_o, 0);
        check("done ready", ready_o, 0);
        check("done sclk", sclk_o, cpol);
      end
      if (loopback) miso_i = mosi_o;
      else          miso_i = bit_of(sw, (idx < 0) ? 0 : idx, lsb);
    end
    prev_dout = sw;
    if (!keep_start) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk_i);
        check($sformatf("idle ready %0d", j), ready_o, 1);
        check($sformatf("idle done %0d", j), spi_done_tick_o, 0);
        check($sformatf("idle cs %0d", j), cs_n_o, 4'hF);
        check($sformatf("idle sclk %0d", j), sclk_o, cpol_i);
        check($sformatf("idle dout %0d", j), dout_o, sw);
      end
    end
  endtask

  initial begin
    logic [7:0] d, s;
    reset_i = 1'b0; din_i = '0; start_i = 1'b0; cs_sel_i = '0; cpol_i = 1'b0;
    cpha_i = 1'b0; lsb_first_i = 1'b0; clk_div_i = '0; miso_i = 1'b0;
    prev_dout = '0;
    repeat (2) @(negedge clk_i);
    check_reset("por");
    reset_i = 1'b1;
    @(negedge clk_i);
    check_reset("post reset idle");

    // Mode 0, loopback, H=1, CS 2.
    run_xfer(8'hA5, 8'hA5, 1, 0, 0, 0, 0, 2, 0, -1, -1, -1);
    // Mode 3, LSB first, H=4, MISO fixed high.
    run_xfer(8'h3C, 8'hFF, 0, 1, 1, 1, 3, 0, 0, -1, -1, -1);
    // Modes 1 and 2 against a slave returning 0x5A.
    run_xfer(8'h81, 8'h5A, 0, 0, 1, 0, 1, 1, 0, -1, -1, -1);
    run_xfer(8'h81, 8'h5A, 0, 1, 0, 0, 2, 3, 0, -1, -1, -1);
    // Start pulsed mid-transfer is ignored and not queued.
    run_xfer(8'hC3, 8'h96, 0, 0, 0, 1, 1, 0, 0, 7, -1, -1);
    // Start held high: two transfers back-to-back, CS high for DONE + IDLE.
    run_xfer(8'h12, 8'hE7, 0, 0, 1, 0, 0, 1, 1, -1, -1, -1);
    run_xfer(8'h34, 8'h6B, 0, 1, 1, 1, 1, 2, 0, -1, -1, 1);
    // Out-of-range chip select: no CS line, nominal timing.
    run_xfer(8'h5C, 8'hA3, 0, 0, 0, 0, 1, 5, 0, -1, -1, -1);
    // Reset at the bit-4 leading edge of a mode-0 transfer with H=2.
    run_xfer(8'h77, 8'h33, 0, 0, 0, 0, 1, 1, 0, -1, 18, -1);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_i);
      check_reset($sformatf("rst hold %0d", j));
    end
    reset_i = 1'b1;
    prev_dout = '0;
    run_xfer(8'h0F, 8'hB1, 0, 0, 0, 0, 1, 1, 0, -1, -1, -1);

    for (int r = 0; r < 12; r++) begin
      d = 8'($urandom);
      s = 8'($urandom);
      run_xfer(d, s, 0, 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 4), $urandom_range(0, 7), 0, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
- Parametrised SPI master, next generation of the fixed 8-bit mode-0 SPI master driven by the spi_uvc agent.
- Generalises the data width and the number of chip selects.
- Adds runtime CPOL/CPHA mode, LSB/MSB-first order and a programmable SCLK divider.
- Sits between a local start/data handshake and the external SPI pins. Keeps the same handshake: ready_o, start_i, spi_done_tick_o.

Parameters:
- DATA_W, 8: bits per transfer (2..32).
- NUM_CS, 4: number of chip-select lines (1..16). CS_W = max(1, clog2(NUM_CS)).
- DIV_W, 16: width of the clock-divider input.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset, asynchronous, active-low.
- din_i  in  DATA_W  transmit word, sampled when start is accepted.
- start_i  in  1  start request; accepted only while ready_o=1.
- cs_sel_i  in  CS_W  target slave index, sampled at start.
- cpol_i  in  1  SCLK idle level, sampled at start.
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge. Sampled at start.
- lsb_first_i  in  1  1: shift LSB first. Sampled at start.
- clk_div_i  in  DIV_W  SCLK half-period minus 1, in clk_i cycles. Sampled at start.
- miso_i  in  1  serial data from slave.
- dout_o  out  DATA_W  last received word.
- spi_done_tick_o  out  1  one-cycle pulse at transfer end.
- ready_o  out  1  idle, able to accept start.
- sclk_o  out  1  SPI clock.
- mosi_o  out  1  serial data to slave.
- cs_n_o  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset values (reset_i=0, asynchronous): dout_o=0, spi_done_tick_o=0, ready_o=1, sclk_o=0, mosi_o=0, cs_n_o=all 1s, state IDLE, all counters 0.
- Reset mid-transfer aborts immediately to these values. No done tick is produced.
- Half period H = clk_div_i+1 clk_i cycles, so clk_div_i=0 gives H=1. The maximum is 2^DIV_W.
- States: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - ready_o=1. sclk_o = cpol_i registered, i.e. it follows cpol_i with a one-cycle lag.
  - Start is accepted on the edge where start_i=1 and ready_o=1 (call it edge T).
  - At T, latch din_i, cs_sel_i, cpol_i, cpha_i, lsb_first_i and clk_div_i. Later changes to these inputs are ignored until the next IDLE.
- SETUP (H cycles):
  - From T+1: ready_o=0 and cs_n_o[cs_sel]=0.
  - If cs_sel >= NUM_CS, no CS line asserts but the transfer still runs.
  - sclk_o = CPOL.
  - CPHA=0: mosi_o presents the first bit (MSB, or LSB if lsb_first) from T+1.
- XFER (2*DATA_W*H cycles): sclk_o toggles every H cycles, giving DATA_W full SCLK periods. The first toggle is a leading edge.
  - CPHA=0: sample miso_i on leading edges; shift mosi_o to the next bit on trailing edges, except after the last bit.
  - CPHA=1: shift mosi_o on leading edges (the first leading edge presents bit 0); sample miso_i on trailing edges.
  - Receive word is assembled in the same bit order as transmit.
- HOLD (H cycles): sclk_o = CPOL, CS still asserted, mosi_o holds the last bit.
- DONE (1 cycle), at cycle T+1+H*(2*DATA_W+2):
  - spi_done_tick_o=1 and dout_o updated with the received word.
  - cs_n_o all 1s and mosi_o=0.
  - ready_o returns to 1 on the next cycle (IDLE).
  - dout_o holds until the next DONE.
- start_i while ready_o=0 is ignored and not queued.
- Back-to-back: start_i held high is accepted on the first IDLE cycle. Minimum gap is CS high for 2 cycles (DONE + IDLE).
- The bit counter is exactly clog2(DATA_W)+1 bits wide. The divider counter is DIV_W bits and compares against the latched clk_div, with no wrap.
- miso_i is sampled directly. Synchronisation of miso_i is the board's responsibility.

Test Plan:
- Mode 0, DATA_W=8, clk_div=0, cs_sel=2, din=0xA5, miso looped to mosi:
  - cs_n_o=4'b1011 from T+1.
  - 8 SCLK rising edges, mosi sequence 1,0,1,0,0,1,0,1.
  - done tick at T+19, dout_o=0xA5.
- Mode 3 (CPOL=1, CPHA=1), clk_div=3, lsb_first=1, din=0x3C, miso fixed 1:
  - sclk idle high, half period 4 cycles.
  - mosi sequence 0,0,1,1,1,1,0,0.
  - done at T+73, dout_o=0xFF.
- Modes 1 and 2 with din=0x81 and a bench slave model returning 0x5A: dout_o=0x5A in both modes; edge alignment is checked per mode.
- start_i pulsed mid-transfer and start_i held high: the mid-transfer pulse is ignored; exactly two transfers occur, with CS high for 2 cycles between them.
- reset_i low mid-XFER (bit 4): outputs immediately at reset values, no done tick. A following transfer of 0x0F completes correctly.
- cs_sel=5 with NUM_CS=4 (CS_W=3): cs_n_o stays 4'b1111 and the done tick still arrives at the nominal cycle.
